// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

   // Top-level engine states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // Metastability flops ahead of the history flop on every pin
   localparam int SYNC_STAGES = 2;

   // Only CPOL=0/CPHA=0 is implemented
   localparam int SPI_MODE = 0;

endpackage

// File: rtl/spi_sync.sv
// Pin synchroniser with a history flop for single-cycle edge pulses.
// Latency: SYNC_STAGES clk to level, edge pulse one clk wide alongside it.
// Backpressure: none; free-running sampler.
module spi_sync
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Shift the raw pin through the synchroniser, then remember the last settled value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave bit engine between the pins and the RX/TX word FIFOs.
// Latency: word pushed to RX one clk after the synchronised last SCLK rise.
// Backpressure: none toward the host; full RX drops the word, empty TX sends FILL.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] FILL  = 8'hFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_wr_en,
   input  logic             rx_full,
   input  logic [WIDTH-1:0] tx_rd_data,
   output logic             tx_rd_en,
   input  logic             tx_empty,
   input  logic             err_clr,
   output logic             rx_overflow,
   output logic             tx_underrun
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   // Synchronised pin views
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_fall, cs_rise;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sclk),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (mosi),
      .level (mosi_lvl),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   // Only levels/edges that the engine consumes are used; the rest are sinks
   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rx_shift_q;
   logic [WIDTH-1:0] tx_shift_q;
   logic [WIDTH-1:0] tx_next_q;
   logic             pend_q;
   logic             req_q;     // high in the cycle tx_rd_en is on the bus
   logic             fetch_q;   // high in the cycle tx_rd_data is valid
   logic             fill_q;    // the outstanding fetch is FILL, not FIFO data
   logic             miso_q;
   logic             miso_oe_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_wr_en_q;
   logic             tx_rd_en_q;
   logic             rx_overflow_q;
   logic             tx_underrun_q;

   logic [WIDTH-1:0] rx_word_d;
   logic [WIDTH-1:0] tx_word_d;

   assign rx_word_d = {rx_shift_q[WIDTH-2:0], mosi_lvl};
   assign tx_word_d = fill_q ? FILL : tx_rd_data;

   // Engine FSM: pops/loads TX words, shifts both directions, raises strobes and sticky errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         tx_next_q     <= '0;
         pend_q        <= 1'b0;
         req_q         <= 1'b0;
         fetch_q       <= 1'b0;
         fill_q        <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         rx_data_q     <= '0;
         rx_wr_en_q    <= 1'b0;
         tx_rd_en_q    <= 1'b0;
         rx_overflow_q <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         rx_wr_en_q <= 1'b0;
         tx_rd_en_q <= 1'b0;
         req_q      <= 1'b0;
         fetch_q    <= 1'b0;

         // Clear first so that a set later in this cycle takes priority
         if (err_clr) begin
            rx_overflow_q <= 1'b0;
            tx_underrun_q <= 1'b0;
         end

         if (cs_rise) begin
            // Deselect drops any partial RX word and any prefetched TX word
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  miso_oe_q <= 1'b0;
                  if (req_q) begin
                     // Pop strobe is on the bus now; data arrives during LOAD
                     state_q <= LOAD;
                  end else if (cs_fall) begin
                     req_q  <= 1'b1;
                     fill_q <= tx_empty;
                     if (!tx_empty) tx_rd_en_q    <= 1'b1;
                     else           tx_underrun_q <= 1'b1;
                  end
               end

               LOAD: begin
                  tx_shift_q <= tx_word_d;
                  miso_q     <= tx_word_d[WIDTH-1];
                  miso_oe_q  <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= ACTIVE;
               end

               ACTIVE: begin
                  if (req_q) fetch_q <= 1'b1;

                  if (fetch_q) begin
                     tx_next_q <= tx_word_d;
                     pend_q    <= 1'b1;
                  end

                  if (sclk_rise && !cs_lvl) begin
                     rx_shift_q <= rx_word_d;
                     if (cnt_q == LAST) begin
                        cnt_q     <= '0;
                        rx_data_q <= rx_word_d;
                        if (!rx_full) rx_wr_en_q    <= 1'b1;
                        else          rx_overflow_q <= 1'b1;
                        // Prefetch the next TX word right away
                        req_q  <= 1'b1;
                        fill_q <= tx_empty;
                        if (!tx_empty) tx_rd_en_q    <= 1'b1;
                        else           tx_underrun_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end

                  if (sclk_fall && !cs_lvl) begin
                     if (pend_q) begin
                        tx_shift_q <= tx_next_q;
                        miso_q     <= tx_next_q[WIDTH-1];
                        pend_q     <= 1'b0;
                     end else begin
                        tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                        miso_q     <= tx_shift_q[WIDTH-2];
                     end
                  end
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign rx_data     = rx_data_q;
   assign rx_wr_en    = rx_wr_en_q;
   assign tx_rd_en    = tx_rd_en_q;
   assign rx_overflow = rx_overflow_q;
   assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core with simple RX/TX FIFO models.
// Latency: n/a.
// Backpressure: rx_full driven directly by the stimulus.
module tb_spi_slave_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk, cs_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] rx_data;
   logic       rx_wr_en, rx_full;
   logic [7:0] tx_rd_data = 8'h00;
   logic       tx_rd_en, tx_empty;
   logic       err_clr;
   logic       rx_overflow, tx_underrun;

   always #5 clk = ~clk;

   spi_slave_core #(.WIDTH(8), .FILL(8'hFF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .rx_data     (rx_data),
      .rx_wr_en    (rx_wr_en),
      .rx_full     (rx_full),
      .tx_rd_data  (tx_rd_data),
      .tx_rd_en    (tx_rd_en),
      .tx_empty    (tx_empty),
      .err_clr     (err_clr),
      .rx_overflow (rx_overflow),
      .tx_underrun (tx_underrun)
   );

   // TX FIFO model: registered read data, valid the cycle after tx_rd_en
   logic [7:0] tx_mem [0:63];
   logic [5:0] tx_wp = 6'd0;
   logic [5:0] tx_rp = 6'd0;
   assign tx_empty = (tx_wp == tx_rp);

   always @(posedge clk) begin
      if (tx_rd_en && (tx_wp != tx_rp)) begin
         tx_rd_data <= tx_mem[tx_rp];
         tx_rp      <= tx_rp + 6'd1;
      end
   end

   // RX FIFO model and strobe counters
   logic [7:0] rx_mem [0:63];
   logic [5:0] rx_wp = 6'd0;
   int         rd_total = 0;

   always @(negedge clk) begin
      if (rx_wr_en) begin
         rx_mem[rx_wp] <= rx_data;
         rx_wp         <= rx_wp + 6'd1;
      end
      if (tx_rd_en) rd_total <= rd_total + 1;
   end

   logic [7:0] host_tx [0:3];
   logic [7:0] host_rx [0:3];
   logic [5:0] rx_base;
   int         rd_base;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] v);
      tx_mem[tx_wp] = v;
      tx_wp = tx_wp + 6'd1;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      @(negedge clk);
   endtask

   // Host master: mode 0, MSB first, 5-clk SCLK phases; abort_bits>0 releases CS early
   task automatic xfer(input int nwords, input int abort_bits);
      int nb;
      int k;
      bit done;
      nb   = 0;
      done = 1'b0;
      rx_base = rx_wp;
      rd_base = rd_total;
      cs_n = 1'b0;
      repeat (10) @(negedge clk);
      for (int w = 0; w < nwords && !done; w++) begin
         for (int b = 7; b >= 0 && !done; b--) begin
            mosi = host_tx[w][b];
            repeat (5) @(negedge clk);
            host_rx[w][b] = miso;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            nb++;
            if (nb == abort_bits) done = 1'b1;
         end
      end
      if (abort_bits != 0) begin
         cs_n = 1'b1;
         for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!miso_oe) break;
         end
         chk("abort_oe_within_4clk", 32'(k <= 4), 32'd1);
      end else begin
         repeat (5) @(negedge clk);
         cs_n = 1'b1;
      end
      mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      sclk    = 1'b0;
      cs_n    = 1'b1;
      mosi    = 1'b0;
      rx_full = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", 32'({miso, miso_oe, rx_wr_en, tx_rd_en, rx_overflow, tx_underrun}), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single word; a spare word feeds the prefetch after the last bit, so no underrun
      push_tx(8'hA5); push_tx(8'h00);
      host_tx[0] = 8'h3C;
      xfer(1, 0);
      chk("t2_miso_word", 32'(host_rx[0]), 32'hA5);
      chk("t2_rx_count", 32'(6'(rx_wp - rx_base)), 32'd1);
      chk("t2_rx_data", 32'(rx_mem[rx_base]), 32'h3C);
      chk("t2_rd_count", 32'(rd_total - rd_base), 32'd2);
      chk("t2_errors", 32'({rx_overflow, tx_underrun}), 32'd0);

      // Three back-to-back words under one CS; fourth word is the discarded prefetch
      push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44);
      host_tx[0] = 8'h01; host_tx[1] = 8'h80; host_tx[2] = 8'hFF;
      xfer(3, 0);
      chk("t3_miso_w0", 32'(host_rx[0]), 32'h11);
      chk("t3_miso_w1", 32'(host_rx[1]), 32'h22);
      chk("t3_miso_w2", 32'(host_rx[2]), 32'h33);
      chk("t3_rx_count", 32'(6'(rx_wp - rx_base)), 32'd3);
      chk("t3_rx_w0", 32'(rx_mem[rx_base]), 32'h01);
      chk("t3_rx_w1", 32'(rx_mem[6'(rx_base + 6'd1)]), 32'h80);
      chk("t3_rx_w2", 32'(rx_mem[6'(rx_base + 6'd2)]), 32'hFF);
      chk("t3_rd_count", 32'(rd_total - rd_base), 32'd4);
      chk("t3_tx_drained", 32'(tx_empty), 32'd1);
      chk("t3_errors", 32'({rx_overflow, tx_underrun}), 32'd0);

      // Empty TX FIFO: FILL on MISO, no pops, sticky underrun until err_clr
      host_tx[0] = 8'h69;
      xfer(1, 0);
      chk("t4_miso_fill", 32'(host_rx[0]), 32'hFF);
      chk("t4_rd_count", 32'(rd_total - rd_base), 32'd0);
      chk("t4_underrun", 32'(tx_underrun), 32'd1);
      chk("t4_rx_data", 32'(rx_mem[rx_base]), 32'h69);
      pulse_err_clr();
      chk("t4_underrun_clr", 32'(tx_underrun), 32'd0);

      // RX full at the last bit: word dropped, overflow sticky across a good word
      push_tx(8'h00); push_tx(8'h00);
      rx_full = 1'b1;
      host_tx[0] = 8'h5A;
      xfer(1, 0);
      chk("t5_rx_dropped", 32'(6'(rx_wp - rx_base)), 32'd0);
      chk("t5_overflow", 32'(rx_overflow), 32'd1);
      chk("t5_no_underrun", 32'(tx_underrun), 32'd0);
      rx_full = 1'b0;
      push_tx(8'h00); push_tx(8'h00);
      host_tx[0] = 8'h96;
      xfer(1, 0);
      chk("t5_rx_count", 32'(6'(rx_wp - rx_base)), 32'd1);
      chk("t5_rx_data", 32'(rx_mem[rx_base]), 32'h96);
      chk("t5_overflow_sticky", 32'(rx_overflow), 32'd1);
      pulse_err_clr();
      chk("t5_overflow_clr", 32'(rx_overflow), 32'd0);

      // CS released after 5 bits: no write; next transfer starts from bit 0
      push_tx(8'h00);
      host_tx[0] = 8'hFF;
      xfer(1, 5);
      chk("t6_abort_no_write", 32'(6'(rx_wp - rx_base)), 32'd0);
      push_tx(8'h5C); push_tx(8'h00);
      host_tx[0] = 8'hC3;
      xfer(1, 0);
      chk("t6_rx_count", 32'(6'(rx_wp - rx_base)), 32'd1);
      chk("t6_rx_data", 32'(rx_mem[rx_base]), 32'hC3);
      chk("t6_miso_word", 32'(host_rx[0]), 32'h5C);

      // Asynchronous reset in the middle of a word
      push_tx(8'hAB); push_tx(8'hCD);
      cs_n = 1'b0;
      repeat (10) @(negedge clk);
      for (int b = 0; b < 3; b++) begin
         mosi = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
      chk("t1_oe_before_rst", 32'(miso_oe), 32'd1);
      #2;
      rst_n = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      #1;
      chk("t1_async_rst_outputs", 32'({miso, miso_oe, rx_wr_en, tx_rd_en, rx_overflow, tx_underrun}), 32'd0);
      chk("t1_async_rst_rx_data", 32'(rx_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      tx_wp = tx_rp;
      push_tx(8'h7E); push_tx(8'h00);
      host_tx[0] = 8'h81;
      xfer(1, 0);
      chk("t1_rx_count", 32'(6'(rx_wp - rx_base)), 32'd1);
      chk("t1_rx_data", 32'(rx_mem[rx_base]), 32'h81);
      chk("t1_miso_word", 32'(host_rx[0]), 32'h7E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
